// File: rtl/scaler_readout_sequencer.sv
// Scaler readout sequencer: issues the bank latch flag on a periodic tick or
// on demand, waits for the frozen values to settle, then walks the bank mux
// and presents each value on a valid/ready stream with address and last tag.
module scaler_readout_sequencer #(
  parameter int NUM_SCALERS   = 16,
  parameter int ADDR_BITS     = 4,
  parameter int SCALER_BITS   = 16,
  parameter int PERIOD_BITS   = 27,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic [PERIOD_BITS-1:0] period_i,
  input  logic                   force_latch_i,
  output logic                   latch_o,
  output logic [ADDR_BITS-1:0]   scaler_addr_o,
  input  logic [SCALER_BITS-1:0] scaler_dat_i,
  output logic [SCALER_BITS-1:0] dat_o,
  output logic [ADDR_BITS-1:0]   dat_addr_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic [7:0]             missed_o
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]     SETTLE_END = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_SCALERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_FETCH, S_PRESENT
  } state_e;

  state_e                 state_q, state_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic [7:0]             missed_q, missed_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic                   fetch_ph_q, fetch_ph_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [SCALER_BITS-1:0] dat_q, dat_d;
  logic [ADDR_BITS-1:0]   dat_addr_q, dat_addr_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   tick;
  logic                   req;

  // Interval counter: reloads while disabled, ticks when it reaches zero.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = period_i;
    end else if (cnt_q == '0) begin
      tick  = 1'b1;
      cnt_d = period_i;
    end else begin
      cnt_d = cnt_q - PERIOD_BITS'(1);
    end
  end

  // One-deep request latch plus sequencing FSM next-state and datapath.
  always_comb begin
    req        = tick | force_latch_i;
    state_d    = state_q;
    pending_d  = pending_q;
    missed_d   = missed_q;
    settle_d   = settle_q;
    fetch_ph_d = fetch_ph_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    dat_addr_d = dat_addr_q;
    valid_d    = valid_q;
    last_d     = last_q;

    // The LATCH cycle consumes the pending request; a request landing in
    // that same cycle becomes the next pending one rather than a drop.
    if (state_q == S_LATCH) begin
      pending_d = req;
    end else if (req) begin
      if (pending_q) begin
        if (missed_q != 8'hFF) missed_d = missed_q + 8'd1;
      end else begin
        pending_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (pending_q) state_d = S_LATCH;
      end
      S_LATCH: begin
        addr_d   = '0;
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_END) begin
          fetch_ph_d = 1'b0;
          state_d    = S_FETCH;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_FETCH: begin
        // Mux is registered: data for a new address is good on the 2nd cycle.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          dat_d      = scaler_dat_i;
          dat_addr_d = addr_q;
          valid_d    = 1'b1;
          last_d     = (addr_q == LAST_ADDR);
          state_d    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (last_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + ADDR_BITS'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      missed_q   <= '0;
      settle_q   <= '0;
      fetch_ph_q <= 1'b0;
      addr_q     <= '0;
      dat_q      <= '0;
      dat_addr_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      missed_q   <= missed_d;
      settle_q   <= settle_d;
      fetch_ph_q <= fetch_ph_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      dat_addr_q <= dat_addr_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
    end
  end

  assign latch_o       = (state_q == S_LATCH);
  assign busy_o        = (state_q != S_IDLE);
  assign scaler_addr_o = addr_q;
  assign dat_o         = dat_q;
  assign dat_addr_o    = dat_addr_q;
  assign valid_o       = valid_q;
  assign last_o        = last_q;
  assign missed_o      = missed_q;

endmodule

// File: tb/tb_scaler_readout_sequencer.sv
// Bench for scaler_readout_sequencer: event-timed model plus directed tests.
module tb_scaler_readout_sequencer;
  localparam int N  = 4;
  localparam int AB = 4;
  localparam int SB = 16;
  localparam int PB = 27;
  localparam int SC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PB-1:0] period = '0;
  logic          force_latch = 1'b0;
  logic          ready = 1'b1;
  logic [SB-1:0] scaler_dat = '0;
  logic          latch_o, valid_o, last_o, busy_o;
  logic [AB-1:0] scaler_addr_o, dat_addr_o;
  logic [SB-1:0] dat_o;
  logic [7:0]    missed_o;

  scaler_readout_sequencer #(
    .NUM_SCALERS(N), .ADDR_BITS(AB), .SCALER_BITS(SB),
    .PERIOD_BITS(PB), .SETTLE_CYCLES(SC)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .period_i(period),
    .force_latch_i(force_latch), .latch_o(latch_o), .scaler_addr_o(scaler_addr_o),
    .scaler_dat_i(scaler_dat), .dat_o(dat_o), .dat_addr_o(dat_addr_o),
    .valid_o(valid_o), .last_o(last_o), .ready_i(ready), .busy_o(busy_o),
    .missed_o(missed_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scaler bank stand-in: values frozen on latch, registered output mux.
  logic [15:0] bank_latches = '0;
  logic [15:0] bank_base = '0;
  always @(posedge clk) begin
    if (latch_o) begin
      bank_base    <= 16'h1000 + (bank_latches << 8);
      bank_latches <= bank_latches + 16'd1;
    end
    scaler_dat <= bank_base + 16'(scaler_addr_o);
  end

  // Model: predicts latch cycles, word presentation windows and drop count.
  int cyc = 0;
  int m_next = -1, m_idle_from = 0, m_vr = 0, m_idx = 0, m_en_start = -1;
  int m_missed = 0, m_nlatch = 0;
  bit m_active = 0, m_pend = 0, m_fresh = 1;
  logic [15:0] m_base = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_pend = 0; m_missed = 0; m_active = 0; m_next = -1;
        m_idle_from = 0; m_fresh = 1; m_en_start = -1;
      end else begin
        bit tick, req, is_latch;
        int p;
        tick = 0;
        if (!enable) begin
          m_fresh = 0; m_en_start = -1;
        end else begin
          if (m_en_start < 0) m_en_start = cyc;
          p = int'(period) + 1;
          tick = (((cyc - m_en_start) % p) == (m_fresh ? 0 : p - 1));
        end
        req = tick || force_latch;
        is_latch = (cyc == m_next);
        if (is_latch) m_pend = req;
        else if (req) begin
          if (m_pend) begin if (m_missed < 255) m_missed++; end
          else m_pend = 1;
        end
        if (m_active && cyc >= m_vr && ready) begin
          if (m_idx == N - 1) begin m_active = 0; m_idle_from = cyc + 1; end
          else begin m_idx++; m_vr = cyc + 3; end
        end
        if (is_latch) begin
          m_active = 1; m_idx = 0; m_vr = cyc + SC + 3; m_next = -1;
          m_base = 16'h1000 + 16'(m_nlatch * 256);
          m_nlatch++;
        end
        if (!m_active && m_next < 0 && m_pend && cyc + 1 >= m_idle_from) m_next = cyc + 2;
      end
      cyc++;
    end
  end

  // Per-cycle compare plus monitors for the directed checks.
  int lcount = 0, last_latch = -1000, first_delta = -1;
  bit prev_v = 0;
  logic [SB-1:0] q_dat[$];
  logic [AB-1:0] q_tag[$];
  logic          q_last[$];
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        bit ev;
        ev = m_active && cyc >= m_vr;
        chk("latch_o", latch_o, cyc == m_next);
        chk("busy_o", busy_o, m_active || cyc == m_next);
        chk("valid_o", valid_o, ev);
        chk("missed_o", missed_o, m_missed);
        if (ev) begin
          chk("dat_o", dat_o, m_base + 16'(m_idx));
          chk("dat_addr_o", dat_addr_o, m_idx);
          chk("last_o", last_o, m_idx == N - 1);
          chk("scaler_addr_o", scaler_addr_o, m_idx);
        end else chk("last_o idle", last_o, 0);
        if (latch_o) begin lcount++; last_latch = cyc; end
        if (valid_o && !prev_v && dat_addr_o == 0) first_delta = cyc - last_latch;
        if (valid_o && ready) begin
          q_dat.push_back(dat_o); q_tag.push_back(dat_addr_o); q_last.push_back(last_o);
        end
        prev_v = valid_o;
      end else prev_v = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_force();
    force_latch = 1'b1; step(1); force_latch = 1'b0;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, " latch_o"}, latch_o, 0);
    chk({tag, " valid_o"}, valid_o, 0);
    chk({tag, " last_o"}, last_o, 0);
    chk({tag, " busy_o"}, busy_o, 0);
    chk({tag, " dat_o"}, dat_o, 0);
    chk({tag, " dat_addr_o"}, dat_addr_o, 0);
    chk({tag, " scaler_addr_o"}, scaler_addr_o, 0);
    chk({tag, " missed_o"}, missed_o, 0);
  endtask

  initial begin
    int l0, q0, r, i;
    logic [SB-1:0] d0;
    step(3);
    chk_zero_outs("reset");
    rst_n = 1'b1;
    step(3);

    // One forced latch, free-running ready.
    q0 = q_dat.size();
    pulse_force();
    step(40);
    chk("t1 latch count", lcount, 1);
    chk("t1 word count", q_dat.size() - q0, 4);
    if (q_dat.size() - q0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("t1 word dat", q_dat[q0 + k], 16'h1000 + 16'(k));
        chk("t1 word tag", q_tag[q0 + k], k);
        chk("t1 word last", q_last[q0 + k], k == 3);
      end
    end
    chk("t1 first valid delay", first_delta, 11);

    // Periodic latching at period 99.
    period = 27'd99;
    step(1);
    enable = 1'b1;
    l0 = lcount;
    step(320);
    enable = 1'b0;
    chk("t2 latch count", lcount - l0, 3);
    chk("t2 missed", missed_o, 0);
    step(40);

    // Backpressure on word 1.
    q0 = q_dat.size();
    pulse_force();
    for (i = 0; i < 100 && !(valid_o && dat_addr_o == 1); i++) step(1);
    chk("t3 wait word1", i < 100, 1);
    ready = 1'b0;
    d0 = dat_o;
    step(20);
    chk("t3 stall start dat", d0, 16'h1401);
    chk("t3 stall end dat", dat_o, 16'h1401);
    chk("t3 stall addr", scaler_addr_o, 1);
    ready = 1'b1;
    step(40);
    chk("t3 word count", q_dat.size() - q0, 4);

    // Readout slower than period: back-to-back latches, drops saturate.
    period = 27'd3;
    step(1);
    enable = 1'b1;
    step(1600);
    chk("t4 missed saturated", missed_o, 8'd255);
    enable = 1'b0;

    // Async reset while a word is presented.
    for (i = 0; i < 100 && !valid_o; i++) step(1);
    chk("t5 wait valid", i < 100, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero_outs("async reset");
    step(2);
    rst_n = 1'b1;
    l0 = lcount;
    step(30);
    chk("t5 no latch after reset", lcount - l0, 0);

    // Enabled straight out of reset, then tick coinciding with force.
    #2 rst_n = 1'b0;
    enable = 1'b1;
    period = 27'd49;
    step(2);
    rst_n = 1'b1;
    r = cyc;
    step(5);
    chk("t6 first latch cycle", last_latch - r, 2);
    while (cyc < r + 45) step(1);
    l0 = lcount;
    while (cyc < r + 50) step(1);
    pulse_force();
    step(10);
    chk("t6 single latch", lcount - l0, 1);
    chk("t6 missed", missed_o, 0);
    enable = 1'b0;
    step(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scaler_readout_sequencer.md
# scaler_readout_sequencer

Single-clock sequencer that drives the other end of the scaler bank interface. It periodically, or on demand, issues the one-cycle latch flag that freezes every `par_and_var_scaler` value. It then waits for the latched values to settle into the readout clock domain and walks an address across the bank's output mux. Each latched value is presented on a valid/ready stream toward the event/housekeeping packer, tagged with its address and a last-word marker.

## Interface
Parameters:
- NUM_SCALERS, 16, number of scalers in the bank (2..2^ADDR_BITS)
- ADDR_BITS, 4, width of scaler select
- SCALER_BITS, 16, width of one scaler value (matches scaler OUTPUT_BITS)
- PERIOD_BITS, 27, width of latch interval counter
- SETTLE_CYCLES, 8, wait after latch before first read (covers clkA→clkB flag sync); ≥1

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  readout clock (scaler clkB domain)
- rst_n_i  in  1  asynchronous active-low reset
- enable_i  in  1  enables periodic latching
- period_i  in  PERIOD_BITS  latch interval minus one, in clk_i cycles
- force_latch_i  in  1  single-cycle request for an immediate latch
- latch_o  out  1  single-cycle latch flag to the scaler bank
- scaler_addr_o  out  ADDR_BITS  bank mux select
- scaler_dat_i  in  SCALER_BITS  selected value; registered mux, valid 2 cycles after address change
- dat_o  out  SCALER_BITS  stream data
- dat_addr_o  out  ADDR_BITS  address tag of dat_o
- valid_o  out  1  stream valid
- last_o  out  1  high with valid_o on word NUM_SCALERS-1
- ready_i  in  1  stream ready
- busy_o  out  1  high in any state except IDLE
- missed_o  out  8  saturating count of dropped latch requests

## Operation
- Interval counter:
  - enable_i low: loads period_i every cycle.
  - enable_i high: counter at 0 → tick and reload period_i; otherwise decrement.
  - Reset value is 0, so enabling straight out of reset ticks on the first enabled cycle.
- Request = tick OR force_latch_i. Simultaneous tick and force count as one request.
- One-deep pending bit.
  - A request with pending clear sets pending.
  - A request with pending already set is dropped, and missed_o increments (saturates at 255, never wraps; cleared only by reset).
- FSM states: IDLE, LATCH, SETTLE, FETCH, PRESENT.
  - IDLE: pending set → LATCH.
  - LATCH: latch_o=1 for exactly this cycle; clear pending (a same-cycle new request re-sets it); scaler_addr_o←0 → SETTLE.
  - SETTLE: SETTLE_CYCLES cycles → FETCH.
  - FETCH: 2 cycles. At the second cycle's edge: dat_o←scaler_dat_i, dat_addr_o←scaler_addr_o, valid_o←1, last_o←(addr==NUM_SCALERS-1) → PRESENT.
  - PRESENT: hold dat_o/dat_addr_o/last_o/valid_o stable until valid_o&&ready_i. At that edge:
    - valid_o←0, last_o←0.
    - If last word → IDLE; else scaler_addr_o+1 → FETCH.
- Requests arriving while busy are held in pending; the next latch follows immediately after return to IDLE. No new latch is issued mid-readout.
- enable_i deassert mid-readout: the current readout completes; a pending request is still serviced.
- scaler_addr_o never exceeds NUM_SCALERS-1.

## Timing
- Reset (async assert, sync release): state IDLE; latch_o, valid_o, last_o, busy_o = 0; dat_o, dat_addr_o, scaler_addr_o, missed_o, counter, pending = 0.
- Request at edge E sets pending. LATCH, with latch_o high, occupies cycle E+1.
- First valid_o rises SETTLE_CYCLES+3 cycles after latch_o.
- With ready_i held high, each word takes 3 cycles: a full sweep takes 3·NUM_SCALERS cycles of FETCH/PRESENT.
- Latch period with enable_i steady: period_i+1 cycles between ticks. Latches occur at that rate only if the readout finishes within the period; otherwise latches fall back to back-to-readout, and missed_o counts the excess.

## Test plan
- NUM_SCALERS=4, SETTLE_CYCLES=8, enable_i=0, one force_latch_i pulse, ready_i=1, scaler_dat_i = 16'h1000+addr → latch_o one cycle; 4 words 1000,1001,1002,1003 with tags 0–3; last_o only on tag 3; first valid_o 11 cycles after latch_o.
- enable_i=1, period_i=99, ready_i=1 → latch_o every 100 cycles; missed_o stays 0.
- Backpressure: ready_i low for 20 cycles on word 1 → dat_o/dat_addr_o stable throughout; scaler_addr_o unchanged; no words lost or duplicated.
- period_i=3, readout slower than period → one latch per sweep, issued the cycle after IDLE; missed_o increments per dropped tick and saturates at 255.
- Tick and force_latch_i in the same cycle → single pending request; exactly one latch_o; missed_o unchanged.
- rst_n_i asserted in PRESENT with valid_o high → all outputs 0 immediately (asynchronously); after release, no latch until a new request; with enable_i=1 a tick occurs on the first enabled cycle.
